rk4_datapath: RTL and testbench

Arithmetic engine controlled by `fsm_rk4`. It integrates dy/dx = (x − y)/2 with classical 4th-order Runge-Kutta in signed fixed point, one k-term per clock. It advances while `SEL`=1 and reports `LIMIT` back to the controller. On the controller's `LD` pulse it publishes the working (x, y) pair to its output registers.

---
 rtl/rk4_datapath.sv | 140 ++++++++++++++
 tb/tb_rk4_datapath.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rk4_datapath.sv
// RK4 integrator for dy/dx = (x - y)/2 in signed fixed point, one k-term per clock.
// Define RK4_STEP_CAP_EN to also stop integration once CNT reaches MAX_STEPS.
`timescale 1ns/1ps
module rk4_datapath #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC      = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_STEPS = 200
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    SEL,
  input  logic                    LD,
  input  logic signed [WIDTH-1:0] X0,
  input  logic signed [WIDTH-1:0] Y0,
  input  logic signed [WIDTH-1:0] H,
  input  logic signed [WIDTH-1:0] X_END,
  output logic signed [WIDTH-1:0] X_OUT,
  output logic signed [WIDTH-1:0] Y_OUT,
  output logic [CNT_W-1:0]        CNT,
  output logic                    LIMIT,
  output logic                    LOW_LIM
);

`ifdef RK4_STEP_CAP_EN
  localparam bit CapOn = 1'b1;
`else
  localparam bit CapOn = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CapCnt = CNT_W'(MAX_STEPS);
  localparam int unsigned SW = WIDTH + 3;
  localparam logic signed [SW-1:0] Six = SW'(6);

  typedef enum logic [2:0] {StIdle, StLoad, StK1, StK2, StK3, StK4, StUpd} st_e;

  st_e st, st_nxt;

  logic signed [WIDTH-1:0]   x_r, y_r, k1, k2, k3, k4;
  logic                      loaded;
  logic signed [WIDTH-1:0]   h_half, fa, fb, diff, fval, kval, y_upd;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [SW-1:0]      ssum, squot;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) st <= StIdle;
    else     st <= st_nxt;
  end

  // Next-state logic; once K1 is entered the step runs to UPD regardless of SEL
  always_comb begin
    st_nxt = st;
    unique case (st)
      StIdle: begin
        if (SEL && !loaded)     st_nxt = StLoad;
        else if (SEL && !LIMIT) st_nxt = StK1;
      end
      StLoad:  st_nxt = StIdle;
      StK1:    st_nxt = StK2;
      StK2:    st_nxt = StK3;
      StK3:    st_nxt = StK4;
      StK4:    st_nxt = StUpd;
      StUpd:   st_nxt = StIdle;
      default: st_nxt = StIdle;
    endcase
  end

  // Status outputs
  always_comb begin
    LIMIT   = loaded && ((x_r >= X_END) || (CapOn && (CNT == CapCnt)));
    LOW_LIM = loaded && y_r[WIDTH-1];
  end

  // Shared slope evaluator: operands of f() are chosen by the current k-state
  always_comb begin
    h_half = H >>> 1;
    fa     = x_r;
    fb     = y_r;
    unique case (st)
      StK2: begin
        fa = x_r + h_half;
        fb = y_r + (k1 >>> 1);
      end
      StK3: begin
        fa = x_r + h_half;
        fb = y_r + (k2 >>> 1);
      end
      StK4: begin
        fa = x_r + H;
        fb = y_r + k3;
      end
      default: ;
    endcase
    diff  = fa - fb;
    fval  = diff >>> 1;
    prod  = H * fval;
    kval  = WIDTH'(prod >>> FRAC);
    ssum  = SW'(k1) + (SW'(k2) <<< 1) + (SW'(k3) <<< 1) + SW'(k4);
    squot = ssum / Six;
    y_upd = y_r + WIDTH'(squot);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_r    <= '0;
      y_r    <= '0;
      k1     <= '0;
      k2     <= '0;
      k3     <= '0;
      k4     <= '0;
      loaded <= 1'b0;
      CNT    <= '0;
      X_OUT  <= '0;
      Y_OUT  <= '0;
    end else begin
      if (LD) begin
        X_OUT <= x_r;
        Y_OUT <= y_r;
      end
      case (st)
        StLoad: begin
          x_r    <= X0;
          y_r    <= Y0;
          loaded <= 1'b1;
        end
        StK1: k1 <= kval;
        StK2: k2 <= kval;
        StK3: k3 <= kval;
        StK4: k4 <= kval;
        StUpd: begin
          x_r <= x_r + H;
          y_r <= y_upd;
          if (!CapOn || (CNT != CapCnt)) CNT <= CNT + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rk4_datapath.sv
// Self-checking bench for rk4_datapath: vector table with a step scoreboard plus
// hand-written reset, handshake, boundary and step-cap sequences.
`timescale 1ns/1ps
module tb_rk4_datapath;
  localparam int MS = 3;

  logic               CLK = 1'b0;
  logic               RST, SEL, LD;
  logic signed [15:0] X0, Y0, H, X_END;
  logic signed [15:0] X_OUT, Y_OUT;
  logic [7:0]         CNT;
  logic               LIMIT, LOW_LIM;

  rk4_datapath #(.WIDTH(16), .FRAC(8), .CNT_W(8), .MAX_STEPS(MS)) dut (
    .CLK(CLK), .RST(RST), .SEL(SEL), .LD(LD), .X0(X0), .Y0(Y0), .H(H), .X_END(X_END),
    .X_OUT(X_OUT), .Y_OUT(Y_OUT), .CNT(CNT), .LIMIT(LIMIT), .LOW_LIM(LOW_LIM)
  );

  always #5 CLK = ~CLK;

`ifdef RK4_STEP_CAP_EN
  localparam bit Cap = 1'b1;
`else
  localparam bit Cap = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference model of one RK4 step
  function automatic logic signed [15:0] mulq(input logic signed [15:0] h,
                                               input logic signed [15:0] p);
    int pr;
    pr = int'(h) * int'(p);
    return 16'(pr >>> 8);
  endfunction

  function automatic logic signed [15:0] fq(input logic signed [15:0] a,
                                             input logic signed [15:0] b);
    logic signed [15:0] d;
    d = a - b;
    return d >>> 1;
  endfunction

  function automatic logic signed [15:0] rk_y(input logic signed [15:0] x,
                                               input logic signed [15:0] y,
                                               input logic signed [15:0] h);
    logic signed [15:0] hh, k1, k2, k3, k4, xa, ya;
    int s;
    hh = h >>> 1;
    k1 = mulq(h, fq(x, y));
    xa = x + hh;
    ya = y + (k1 >>> 1);
    k2 = mulq(h, fq(xa, ya));
    ya = y + (k2 >>> 1);
    k3 = mulq(h, fq(xa, ya));
    xa = x + h;
    ya = y + k3;
    k4 = mulq(h, fq(xa, ya));
    s  = int'(k1) + 2 * int'(k2) + 2 * int'(k3) + int'(k4);
    return y + 16'(s / 6);
  endfunction

  typedef struct {
    logic signed [15:0] x0, y0, h, xe;
    int                 steps;
    logic signed [15:0] ex, ey;
  } vec_t;

  typedef struct {
    logic signed [15:0] x, y;
    int                 cnt;
  } exp_t;

  vec_t vecs[5];
  exp_t sbq[$];
  exp_t cur;
  logic mon_en = 1'b0;
  logic pend = 1'b0;
  logic [7:0] prev_cnt = '0;

  // Scoreboard: each CNT increment pops an expectation, checked once LD has captured it
  always @(negedge CLK) begin
    if (!mon_en) begin
      pend     = 1'b0;
      prev_cnt = CNT;
    end else begin
      if (pend) begin
        chk("sb_x", X_OUT, cur.x);
        chk("sb_y", Y_OUT, cur.y);
        chk("sb_cnt", CNT, cur.cnt);
        pend = 1'b0;
      end
      if (CNT == 8'(prev_cnt + 1)) begin
        if (sbq.size() == 0) chk("sb_extra_step", CNT, prev_cnt);
        else begin
          cur  = sbq.pop_front();
          pend = 1'b1;
        end
      end
      prev_cnt = CNT;
    end
  end

  task automatic set_vec(input int i, input logic signed [15:0] x0, input logic signed [15:0] y0,
                         input logic signed [15:0] h, input logic signed [15:0] xe);
    logic signed [15:0] x, y;
    int n;
    x = x0; y = y0; n = 0;
    while (!(x >= xe) && !(Cap && n == MS) && n < 100) begin
      y = rk_y(x, y, h);
      x = x + h;
      n++;
    end
    vecs[i] = '{x0: x0, y0: y0, h: h, xe: xe, steps: n, ex: x, ey: y};
  endtask

  task automatic do_reset(input logic signed [15:0] x0, input logic signed [15:0] y0,
                          input logic signed [15:0] h, input logic signed [15:0] xe);
    RST = 1'b1; SEL = 1'b0; LD = 1'b0;
    X0 = x0; Y0 = y0; H = h; X_END = xe;
    tick();
    RST = 1'b0;
  endtask

  task automatic run_vec(input int i);
    logic signed [15:0] x, y;
    int budget;
    do_reset(vecs[i].x0, vecs[i].y0, vecs[i].h, vecs[i].xe);
    x = vecs[i].x0;
    y = vecs[i].y0;
    for (int n = 1; n <= vecs[i].steps; n++) begin
      y = rk_y(x, y, vecs[i].h);
      x = x + vecs[i].h;
      sbq.push_back('{x: x, y: y, cnt: n});
    end
    mon_en = 1'b1;
    SEL = 1'b1;
    LD  = 1'b1;
    budget = 0;
    while (!(sbq.size() == 0 && LIMIT === 1'b1) && budget < 200) begin
      tick();
      budget++;
    end
    chk("vec_timeout", budget < 200, 1);
    repeat (12) tick();
    chk("vec_cnt", CNT, vecs[i].steps);
    chk("vec_limit", LIMIT, 1);
    chk("vec_low", LOW_LIM, vecs[i].ey[15]);
    chk("vec_xout", X_OUT, vecs[i].ex);
    chk("vec_yout", Y_OUT, vecs[i].ey);
    chk("vec_sb_left", sbq.size(), 0);
    sbq.delete();
    mon_en = 1'b0;
    SEL = 1'b0;
    LD  = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int budget;
    int cnt_at_limit;
    RST = 1'b0; SEL = 1'b0; LD = 1'b0;
    X0 = '0; Y0 = '0; H = '0; X_END = '0;

    set_vec(0, 16'sh0000, 16'sh0100, 16'sh0080, 16'sh0200);
    set_vec(1, 16'sh0100, 16'shFE00, 16'sh0040, 16'sh0200);
    set_vec(2, 16'shFF00, 16'sh0300, 16'sh0100, 16'sh0100);
    set_vec(3, 16'sh0300, 16'sh0050, 16'sh0080, 16'sh0200);
    set_vec(4, 16'sh0000, 16'sh0050, 16'sh0020, 16'sh00A0);

    // Reset held with SEL=1
    X0 = 16'sh0100; Y0 = 16'shFF00; H = 16'sh0080; X_END = 16'sh7FFF;
    RST = 1'b1; SEL = 1'b1; LD = 1'b1;
    repeat (2) tick();
    chk("rst_xout", X_OUT, 0);
    chk("rst_yout", Y_OUT, 0);
    chk("rst_cnt", CNT, 0);
    chk("rst_limit", LIMIT, 0);
    chk("rst_low", LOW_LIM, 0);

    // Single step with known k-terms
    do_reset(16'sh0000, 16'sh0100, 16'sh0080, 16'sh7FFF);
    SEL = 1'b1; LD = 1'b1;
    repeat (8) tick();
    chk("step1_cnt", CNT, 1);
    tick();
    chk("step1_x", X_OUT, 16'sh0080);
    chk("step1_y", Y_OUT, 16'sh00D6);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Controller handshake: drop SEL and pulse LD when LIMIT rises
    do_reset(16'sh0000, 16'sh0100, 16'sh0080, 16'sh0200);
    SEL = 1'b1;
    budget = 0;
    while (LIMIT !== 1'b1 && budget < 200) begin
      tick();
      budget++;
    end
    chk("hs_timeout", budget < 200, 1);
    cnt_at_limit = CNT;
    chk("hs_cnt_at_limit", cnt_at_limit, vecs[0].steps);
    chk("hs_xout_before_ld", X_OUT, 0);
    SEL = 1'b0; LD = 1'b1;
    tick();
    LD = 1'b0;
    chk("hs_xout", X_OUT, Cap ? vecs[0].ex : 16'sh0200);
    chk("hs_yout", Y_OUT, vecs[0].ey);
    repeat (12) tick();
    chk("hs_no_extra_step", CNT, vecs[0].steps);

    // Reset during K3 discards the step; a new run reloads X0/Y0
    do_reset(16'sh0100, 16'shFE00, 16'sh0080, 16'sh7FFF);
    SEL = 1'b1; LD = 1'b1;
    repeat (5) tick();
    chk("mid_pre_yout", Y_OUT, 16'shFE00);
    chk("mid_pre_low", LOW_LIM, 1);
    RST = 1'b1;
    tick();
    chk("mid_xout", X_OUT, 0);
    chk("mid_yout", Y_OUT, 0);
    chk("mid_cnt", CNT, 0);
    chk("mid_low", LOW_LIM, 0);
    chk("mid_limit", LIMIT, 0);
    RST = 1'b0;
    repeat (3) tick();
    chk("mid_reload_x", X_OUT, 16'sh0100);
    chk("mid_reload_y", Y_OUT, 16'shFE00);
    repeat (5) tick();
    chk("mid_step_cnt", CNT, 1);
    tick();
    chk("mid_step_x", X_OUT, 16'sh0180);
    chk("mid_step_y", Y_OUT, rk_y(16'sh0100, 16'shFE00, 16'sh0080));

    // X0 past X_END and negative Y0: flags rise right after LOAD, no steps
    do_reset(16'sh0300, 16'shFF00, 16'sh0080, 16'sh0200);
    SEL = 1'b1;
    tick();
    chk("bnd_limit_pre", LIMIT, 0);
    chk("bnd_low_pre", LOW_LIM, 0);
    tick();
    chk("bnd_limit", LIMIT, 1);
    chk("bnd_low", LOW_LIM, 1);
    repeat (8) tick();
    chk("bnd_cnt", CNT, 0);

    // Step cap
    do_reset(16'sh0000, 16'sh0100, 16'sh0080, 16'sh7FFF);
    SEL = 1'b1;
    repeat (26) tick();
    chk("cap_cnt", CNT, Cap ? MS : 4);
    chk("cap_limit", LIMIT, Cap ? 1 : 0);
    repeat (6) tick();
    chk("cap_cnt_later", CNT, Cap ? MS : 5);
    SEL = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
